// File: rtl/spi_slave_cmd_ctrl_pkg.sv
// Shared constants for the SPI-slave command controller.
// Defines the frame width, the bit positions of the frame fields,
// the opcode and status byte values, and a helper that packs a
// response word. It has no ports.
package spi_cmd_pkg;

   localparam int FRAME_W  = 32;

   // Field offsets within a frame. Bit 0 is the first bit on the wire.
   localparam int OPC_LSB  = 0;
   localparam int ADDR_LSB = 8;
   localparam int DATA_LSB = 16;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] OP_ECHO  = 8'h03;

   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_BAD_OP   = 8'hE1;
   localparam logic [7:0] ST_BAD_ADDR = 8'hE2;

   // The response word uses the same layout as a request:
   // data in the top half, then addr, then status in the low byte.
   function automatic logic [FRAME_W-1:0] make_resp(input logic [15:0] data,
                                                     input logic [7:0]  addr,
                                                     input logic [7:0]  status);
      return {data, addr, status};
   endfunction

endpackage

// File: rtl/spi_slave_cmd_ctrl_if.sv
// SPI request lines from the external master: chip select and MOSI.
//   cs_n : chip select, active low
//   mosi : serial data, master to slave
// Modports:
//   master : drives cs_n and mosi
//   slave  : samples cs_n and mosi
// MISO is a tri-state pin and stays a plain port on the controller.
// The master changes mosi while sclk is low. The slave samples it on
// posedge sclk. There is no back-pressure: every posedge with cs_n low
// moves exactly one bit.
interface spi_slave_cmd_ctrl_if;

   logic cs_n;
   logic mosi;

   modport master (output cs_n, output mosi);
   modport slave  (input  cs_n, input  mosi);

endinterface

// File: rtl/spi_slave_cmd_ctrl_frame_shifter.sv
// Bit-level SPI engine: it receives frames and replays responses.
// Ports:
//   sclk, rst   : serial clock; synchronous active-high reset
//   cs_n, mosi  : chip select (high aborts the frame asynchronously) and data in
//   resp_load   : loads resp_data as the pending response (valid on a commit edge)
//   resp_data   : response word to send during the next frame
//   frame       : the complete received word; valid while commit is high
//   commit      : high while the current posedge delivers bit 31
//   tx_bit      : bit to present on miso (the top level applies the tri-state)
module spi_frame_shifter
   import spi_cmd_pkg::*;
(
   input  logic               sclk,
   input  logic               rst,
   input  logic               cs_n,
   input  logic               mosi,
   input  logic               resp_load,
   input  logic [FRAME_W-1:0] resp_data,
   output logic [FRAME_W-1:0] frame,
   output logic               commit,
   output logic               tx_bit
);

   logic [4:0]         bit_cnt;
   logic [FRAME_W-2:0] rx_shift;   // bit 31 is never stored; it is taken live from mosi
   logic [FRAME_W-1:0] resp_q;
   logic [FRAME_W-1:0] tx_shift;

   // A high cs_n discards the partial frame immediately, so a new selection
   // always starts at bit 0.
   always_ff @(posedge sclk or posedge cs_n) begin
      if (cs_n) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else if (rst) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else begin
         bit_cnt <= bit_cnt + 5'd1;
         if (bit_cnt != 5'd31)
            rx_shift[bit_cnt] <= mosi;
      end
   end

   assign commit = (bit_cnt == 5'd31);
   assign frame  = {mosi, rx_shift};

   always_ff @(posedge sclk) begin
      if (rst)
         resp_q <= '0;
      else if (resp_load)
         resp_q <= resp_data;
   end

   // Wire bit 0 of a frame comes straight from resp_q. Because of this, the
   // falling edge after a commit needs no shift, and an aborted frame replays
   // resp_q in full. After bit 0 has been sampled, tx_shift takes over: it is
   // loaded with resp_q>>1 and then shifts once per falling edge.
   always_ff @(negedge sclk) begin
      if (rst)
         tx_shift <= '0;
      else if (!cs_n && bit_cnt == 5'd1)
         tx_shift <= resp_q >> 1;
      else if (!cs_n && bit_cnt != 5'd0)
         tx_shift <= tx_shift >> 1;
   end

   assign tx_bit = (bit_cnt == 5'd0) ? resp_q[0] : tx_shift[0];

endmodule

// File: rtl/spi_slave_cmd_ctrl.sv
// SPI-slave command controller (mode 0, LSB first, 32-bit frames).
// Each frame is decoded and then executes WRITE, READ, ECHO or NOP on
// a bank of 16-bit registers. The result is shifted out on miso during
// the following frame.
// Ports:
//   sclk, rst   : serial clock; synchronous active-high reset
//   bus         : cs_n / mosi from the SPI master (slave modport)
//   miso        : serial data out; high-Z while cs_n is high
//   frame_done  : one-cycle pulse after the posedge that commits bit 31
//   cmd_err     : sticky error flag; set by an E1/E2 response, cleared by status 00
//   regs_flat   : register bank; reg i is at bits [16i+15:16i]
module spi_slave_cmd_ctrl
   import spi_cmd_pkg::*;
#(
   parameter int          NREGS     = 8,
   parameter logic [15:0] RESET_VAL = 16'h0000
) (
   input  logic                  sclk,
   input  logic                  rst,
   spi_slave_cmd_ctrl_if.slave   bus,
   output wire                   miso,
   output logic                  frame_done,
   output logic                  cmd_err,
   output logic [NREGS*16-1:0]   regs_flat
);

   logic [FRAME_W-1:0] frame;
   logic               commit;
   logic               tx_bit;
   logic [FRAME_W-1:0] resp;

   logic [7:0]  opcode;
   logic [7:0]  addr;
   logic [15:0] data;
   logic        addr_ok;
   logic [15:0] rd_val;
   logic        wr_en;
   logic        err_set;
   logic        err_clr;

   spi_frame_shifter u_shifter (
      .sclk      (sclk),
      .rst       (rst),
      .cs_n      (bus.cs_n),
      .mosi      (bus.mosi),
      .resp_load (commit),
      .resp_data (resp),
      .frame     (frame),
      .commit    (commit),
      .tx_bit    (tx_bit)
   );

   assign miso = bus.cs_n ? 1'bz : tx_bit;

   always_comb begin
      opcode  = frame[OPC_LSB +: 8];
      addr    = frame[ADDR_LSB +: 8];
      data    = frame[DATA_LSB +: 16];
      addr_ok = ({24'h0, addr} < NREGS);

      // The read mux uses the bank as it is before this edge, so a
      // same-edge write cannot affect the read value.
      rd_val = '0;
      for (int i = 0; i < NREGS; i++)
         if (addr == 8'(i))
            rd_val = regs_flat[i*16 +: 16];

      // Default case: illegal opcode.
      resp    = make_resp(16'h0, addr, ST_BAD_OP);
      wr_en   = 1'b0;
      err_set = 1'b1;
      err_clr = 1'b0;
      case (opcode)
         OP_WRITE: begin
            if (addr_ok) begin
               resp    = make_resp(data, addr, ST_OK);
               wr_en   = 1'b1;
               err_set = 1'b0;
               err_clr = 1'b1;
            end else begin
               resp = make_resp(16'h0, addr, ST_BAD_ADDR);
            end
         end
         OP_READ: begin
            if (addr_ok) begin
               resp    = make_resp(rd_val, addr, ST_OK);
               err_set = 1'b0;
               err_clr = 1'b1;
            end else begin
               resp = make_resp(16'h0, addr, ST_BAD_ADDR);
            end
         end
         // The echoed low byte is the ECHO opcode itself. That is not a
         // status value, so cmd_err keeps its current state.
         OP_ECHO: begin
            resp    = frame;
            err_set = 1'b0;
         end
         OP_NOP: begin
            resp    = make_resp(16'h0, 8'h00, ST_OK);
            err_set = 1'b0;
            err_clr = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         regs_flat  <= {NREGS{RESET_VAL}};
         frame_done <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         frame_done <= commit;
         if (commit) begin
            if (wr_en)
               for (int i = 0; i < NREGS; i++)
                  if (addr == 8'(i))
                     regs_flat[i*16 +: 16] <= data;
            if (err_set)
               cmd_err <= 1'b1;
            else if (err_clr)
               cmd_err <= 1'b0;
         end
      end
   end

endmodule
